// File: rtl/tri_edge_raster.sv
// tri_edge_raster: pipelined point-in-triangle tester using orientation-normalised edge functions
module tri_edge_raster #(
    parameter int COORD_W   = 9,
    parameter bit CULL_BACK = 1'b0,
    parameter bit TOP_LEFT  = 1'b1,
    localparam int E_W      = 2*COORD_W + 4
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       tri_valid_in,
    output logic                       tri_ready_out,
    input  logic [3*COORD_W-1:0]       vx_in,
    input  logic [3*COORD_W-1:0]       vy_in,
    input  logic                       valid_in,
    output logic                       ready_out,
    input  logic [COORD_W-1:0]         x_in,
    input  logic [COORD_W-1:0]         y_in,
    output logic                       valid_out,
    input  logic                       ready_in,
    output logic                       in_tri,
    output logic signed [E_W-1:0]      w0,
    output logic signed [E_W-1:0]      w1,
    output logic signed [E_W-1:0]      w2,
    output logic [COORD_W-1:0]         x_out,
    output logic [COORD_W-1:0]         y_out,
    output logic signed [E_W-1:0]      area2_out,
    output logic                       degenerate_out,
    output logic                       backface_out
);
    typedef enum logic [2:0] {IDLE, SETUP_AB, SETUP_C, SETUP_AREA, ACTIVE} state_t;

    state_t                  state_q;
    logic [3*COORD_W-1:0]    vx_q, vy_q;
    logic                    sgn_q;
    logic signed [E_W-1:0]   a_q [3], b_q [3], c_q [3];
    logic signed [E_W-1:0]   a_d [3], b_d [3], c_d [3];
    logic signed [E_W-1:0]   a_n [3], b_n [3], c_n [3];
    logic signed [E_W-1:0]   area_d;
    logic                    v1_q, v2_q;
    logic [COORD_W-1:0]      x1_q, y1_q, x2_q, y2_q;
    logic signed [E_W-1:0]   ax_q [3], by_q [3], e_q [3];
    logic signed [E_W-1:0]   ax_d [3], by_d [3], e_d [3];
    logic [2:0]              pass_d;
    logic                    in_d, adv, px_acc;

    function automatic logic signed [E_W-1:0] ext(input logic [COORD_W-1:0] v);
        return $signed({{(E_W-COORD_W){1'b0}}, v});
    endfunction

    // Edge setup terms, sign-normalised coefficients, per-stage pipeline arithmetic and fill-rule test
    always_comb begin
        area_d = c_q[0] + c_q[1] + c_q[2];
        for (int i = 0; i < 3; i++) begin
            a_d[i]    = ext(vy_q[((i+1)%3)*COORD_W +: COORD_W]) - ext(vy_q[((i+2)%3)*COORD_W +: COORD_W]);
            b_d[i]    = ext(vx_q[((i+2)%3)*COORD_W +: COORD_W]) - ext(vx_q[((i+1)%3)*COORD_W +: COORD_W]);
            c_d[i]    = ext(vx_q[((i+1)%3)*COORD_W +: COORD_W]) * ext(vy_q[((i+2)%3)*COORD_W +: COORD_W])
                      - ext(vx_q[((i+2)%3)*COORD_W +: COORD_W]) * ext(vy_q[((i+1)%3)*COORD_W +: COORD_W]);
            a_n[i]    = sgn_q ? -a_q[i] : a_q[i];
            b_n[i]    = sgn_q ? -b_q[i] : b_q[i];
            c_n[i]    = sgn_q ? -c_q[i] : c_q[i];
            ax_d[i]   = a_n[i] * ext(x_in);
            by_d[i]   = b_n[i] * ext(y_in);
            e_d[i]    = ax_q[i] + by_q[i] + c_n[i];
            pass_d[i] = (!e_q[i][E_W-1] && |e_q[i]) ||
                        (~|e_q[i] && (!TOP_LEFT || (!a_n[i][E_W-1] && |a_n[i]) || (~|a_n[i] && b_n[i][E_W-1])));
        end
        in_d          = &pass_d && !degenerate_out && !(CULL_BACK && backface_out);
        adv           = !valid_out || ready_in;
        ready_out     = state_q == ACTIVE && adv && !tri_valid_in;
        tri_ready_out = state_q == IDLE || (state_q == ACTIVE && !v1_q && !v2_q && !valid_out);
        px_acc        = valid_in && ready_out;
    end

    // Triangle setup FSM: latch vertices, then A/B, then C, then area and orientation
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q        <= IDLE;
            vx_q           <= '0;
            vy_q           <= '0;
            sgn_q          <= 1'b0;
            a_q            <= '{default: '0};
            b_q            <= '{default: '0};
            c_q            <= '{default: '0};
            area2_out      <= '0;
            degenerate_out <= 1'b0;
            backface_out   <= 1'b0;
        end else if (tri_valid_in && tri_ready_out) begin
            state_q <= SETUP_AB;
            vx_q    <= vx_in;
            vy_q    <= vy_in;
        end else if (state_q == SETUP_AB) begin
            state_q <= SETUP_C;
            a_q     <= a_d;
            b_q     <= b_d;
        end else if (state_q == SETUP_C) begin
            state_q <= SETUP_AREA;
            c_q     <= c_d;
        end else if (state_q == SETUP_AREA) begin
            state_q        <= ACTIVE;
            area2_out      <= area_d;
            degenerate_out <= ~|area_d;
            backface_out   <= area_d[E_W-1];
            sgn_q          <= area_d[E_W-1];
        end
    end

    // Three-stage pixel pipeline; every stage freezes together when the output is stalled
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            x1_q      <= '0;
            y1_q      <= '0;
            x2_q      <= '0;
            y2_q      <= '0;
            ax_q      <= '{default: '0};
            by_q      <= '{default: '0};
            e_q       <= '{default: '0};
            valid_out <= 1'b0;
            in_tri    <= 1'b0;
            w0        <= '0;
            w1        <= '0;
            w2        <= '0;
            x_out     <= '0;
            y_out     <= '0;
        end else if (adv) begin
            v1_q      <= px_acc;
            x1_q      <= x_in;
            y1_q      <= y_in;
            ax_q      <= ax_d;
            by_q      <= by_d;
            v2_q      <= v1_q;
            x2_q      <= x1_q;
            y2_q      <= y1_q;
            e_q       <= e_d;
            valid_out <= v2_q;
            if (v2_q) begin
                in_tri <= in_d;
                w0     <= e_q[0];
                w1     <= e_q[1];
                w2     <= e_q[2];
                x_out  <= x2_q;
                y_out  <= y2_q;
            end
        end
    end
endmodule

// File: tb/tb_tri_edge_raster.sv
// tb_tri_edge_raster: randomized scoreboard bench for tri_edge_raster against a cross-product reference model
module tb_tri_edge_raster;
    localparam int CW = 9;
    localparam int EW = 2*CW + 4;

    logic              clk_in = 1'b0;
    logic              rst_n_in = 1'b0;
    logic              tri_valid_in = 1'b0;
    logic              valid_in = 1'b0;
    logic              ready_in = 1'b1;
    logic [3*CW-1:0]   vx_in = '0, vy_in = '0;
    logic [CW-1:0]     x_in = '0, y_in = '0;

    logic              tri_ready_out, ready_out, valid_out, in_tri, degenerate_out, backface_out;
    logic signed [EW-1:0] w0, w1, w2, area2_out;
    logic [CW-1:0]     x_out, y_out;
    logic              tri_ready_out_c, ready_out_c, valid_out_c, in_tri_c, degenerate_out_c, backface_out_c;
    logic signed [EW-1:0] w0_c, w1_c, w2_c, area2_out_c;
    logic [CW-1:0]     x_out_c, y_out_c;

    tri_edge_raster #(.COORD_W(CW), .CULL_BACK(1'b0), .TOP_LEFT(1'b1)) u_dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .tri_valid_in(tri_valid_in), .tri_ready_out(tri_ready_out),
        .vx_in(vx_in), .vy_in(vy_in), .valid_in(valid_in), .ready_out(ready_out), .x_in(x_in), .y_in(y_in),
        .valid_out(valid_out), .ready_in(ready_in), .in_tri(in_tri), .w0(w0), .w1(w1), .w2(w2),
        .x_out(x_out), .y_out(y_out), .area2_out(area2_out), .degenerate_out(degenerate_out),
        .backface_out(backface_out)
    );

    tri_edge_raster #(.COORD_W(CW), .CULL_BACK(1'b1), .TOP_LEFT(1'b1)) u_cull (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .tri_valid_in(tri_valid_in), .tri_ready_out(tri_ready_out_c),
        .vx_in(vx_in), .vy_in(vy_in), .valid_in(valid_in), .ready_out(ready_out_c), .x_in(x_in), .y_in(y_in),
        .valid_out(valid_out_c), .ready_in(ready_in), .in_tri(in_tri_c), .w0(w0_c), .w1(w1_c), .w2(w2_c),
        .x_out(x_out_c), .y_out(y_out_c), .area2_out(area2_out_c), .degenerate_out(degenerate_out_c),
        .backface_out(backface_out_c)
    );

    always #5 clk_in = ~clk_in;

    int vectors = 0;
    int miscompares = 0;
    int rmode = 0;
    longint mvx [3], mvy [3];

    typedef struct {
        logic   in0;
        logic   in1;
        longint w [3];
        longint x;
        longint y;
    } exp_t;
    exp_t exp_q [$];

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint marea();
        return (mvx[1]-mvx[0])*(mvy[2]-mvy[0]) - (mvx[2]-mvx[0])*(mvy[1]-mvy[0]);
    endfunction

    // Reference: cross product of each edge with the pixel offset, flipped for clockwise triangles
    function automatic exp_t model(input longint px, input longint py);
        exp_t   e;
        longint ar, s, dx, dy, ev, av, bv;
        logic   all;
        ar  = marea();
        s   = ar < 0 ? -1 : 1;
        all = ar != 0;
        for (int i = 0; i < 3; i++) begin
            int a, b;
            a  = (i+1) % 3;
            b  = (i+2) % 3;
            dx = mvx[b] - mvx[a];
            dy = mvy[b] - mvy[a];
            ev = s * (dx*(py-mvy[a]) - dy*(px-mvx[a]));
            av = -s * dy;
            bv = s * dx;
            e.w[i] = ev;
            if (!(ev > 0 || (ev == 0 && (av > 0 || (av == 0 && bv < 0))))) all = 1'b0;
        end
        e.in0 = all;
        e.in1 = all && ar > 0;
        e.x   = px;
        e.y   = py;
        return e;
    endfunction

    always @(negedge clk_in) begin : mon
        exp_t e;
        if (rst_n_in) begin
            if (valid_out) begin
                if (exp_q.size() == 0) check("spurious_out", valid_out, 0);
                else begin
                    e = exp_q[0];
                    check("valid_out_c", valid_out_c, 1);
                    check("in_tri", in_tri, e.in0);
                    check("in_tri_cull", in_tri_c, e.in1);
                    check("w0", w0, e.w[0]);
                    check("w1", w1, e.w[1]);
                    check("w2", w2, e.w[2]);
                    check("w0_c", w0_c, e.w[0]);
                    check("w1_c", w1_c, e.w[1]);
                    check("w2_c", w2_c, e.w[2]);
                    check("x_out", x_out, e.x);
                    check("y_out", y_out, e.y);
                    check("x_out_c", x_out_c, e.x);
                    check("y_out_c", y_out_c, e.y);
                    if (ready_in) void'(exp_q.pop_front());
                end
            end
            if (valid_in && ready_out) begin
                check("ready_out_c", ready_out_c, 1);
                exp_q.push_back(model(longint'(x_in), longint'(y_in)));
            end
        end
    end

    initial forever begin
        @(posedge clk_in);
        #1;
        ready_in = rmode == 0 ? 1'b1 : rmode == 1 ? !ready_in : rmode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic load_tri(input longint x0, y0, x1, y1, x2, y2, input bit with_px);
        int n = 0;
        vx_in = {CW'(x2), CW'(x1), CW'(x0)};
        vy_in = {CW'(y2), CW'(y1), CW'(y0)};
        tri_valid_in = 1'b1;
        if (with_px) begin
            x_in = 1;
            y_in = 1;
            valid_in = 1'b1;
        end
        @(negedge clk_in);
        while (!tri_ready_out && n < 200) begin
            n++;
            @(negedge clk_in);
        end
        check("tri_ready", tri_ready_out, 1);
        check("tri_ready_c", tri_ready_out_c, 1);
        if (with_px) check("tri_priority", ready_out, 0);
        mvx = '{x0, x1, x2};
        mvy = '{y0, y1, y2};
        tick();
        tri_valid_in = 1'b0;
        valid_in = 1'b0;
        @(negedge clk_in);
        check("setup_ready", ready_out, 0);
        check("setup_tri_ready", tri_ready_out, 0);
        repeat (3) @(negedge clk_in);
        check("active_ready", ready_out, 1);
        check("area2", area2_out, marea());
        check("area2_c", area2_out_c, marea());
        check("degenerate", degenerate_out, marea() == 0);
        check("backface", backface_out, marea() < 0);
        check("backface_c", backface_out_c, marea() < 0);
        check("degenerate_c", degenerate_out_c, marea() == 0);
        tick();
    endtask

    task automatic send_px(input longint x, input longint y);
        int n = 0;
        x_in = CW'(x);
        y_in = CW'(y);
        valid_in = 1'b1;
        @(negedge clk_in);
        while (!ready_out && n < 500) begin
            n++;
            @(negedge clk_in);
        end
        check("px_accept", ready_out, 1);
        tick();
        valid_in = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            tick();
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        longint r [6];
        longint lim;
        repeat (2) tick();
        @(negedge clk_in);
        check("rst_valid_out", valid_out, 0);
        check("rst_tri_ready", tri_ready_out, 1);
        check("rst_ready_out", ready_out, 0);
        check("rst_area2", area2_out, 0);
        check("rst_in_tri", in_tri, 0);
        check("rst_w0", w0, 0);
        tick();
        rst_n_in = 1'b1;
        tick();

        rmode = 0;
        load_tri(0, 0, 10, 0, 0, 10, 1'b0);
        check("area2_const", area2_out, 100);
        send_px(2, 3);
        @(negedge clk_in);
        @(negedge clk_in);
        check("lat_early", valid_out, 0);
        @(negedge clk_in);
        check("lat_valid", valid_out, 1);
        check("lat_in_tri", in_tri, 1);
        check("lat_w0", w0, 50);
        check("lat_w1", w1, 20);
        check("lat_w2", w2, 30);
        tick();
        send_px(11, 0);
        send_px(5, 5);
        send_px(0, 5);
        drain();

        load_tri(0, 0, 0, 10, 10, 0, 1'b1);
        check("area2_back", area2_out, -100);
        check("backface_const", backface_out, 1);
        send_px(2, 3);
        drain();

        load_tri(0, 0, 5, 5, 9, 9, 1'b0);
        check("degenerate_const", degenerate_out, 1);
        send_px(3, 3);
        send_px(1, 7);
        drain();

        load_tri(2, 1, 14, 3, 5, 13, 1'b0);
        rmode = 1;
        for (int k = 0; k < 8; k++) send_px($urandom_range(0, 15), $urandom_range(0, 15));
        drain();

        rmode = 2;
        for (int t = 0; t < 12; t++) begin
            lim = (t % 2) ? 511 : 15;
            for (int k = 0; k < 6; k++) r[k] = $urandom_range(0, 32'(lim));
            load_tri(r[0], r[1], r[2], r[3], r[4], r[5], t == 3);
            for (int k = 0; k < 20; k++) begin
                send_px($urandom_range(0, 32'(lim)), $urandom_range(0, 32'(lim)));
                if ($urandom_range(0, 3) == 0) tick();
            end
            drain();
        end

        rmode = 3;
        load_tri(0, 0, 10, 0, 0, 10, 1'b0);
        send_px(1, 1);
        send_px(2, 2);
        rst_n_in = 1'b0;
        tick();
        exp_q.delete();
        rst_n_in = 1'b1;
        @(negedge clk_in);
        check("rstf_valid_out", valid_out, 0);
        check("rstf_tri_ready", tri_ready_out, 1);
        check("rstf_in_tri", in_tri, 0);
        check("rstf_w0", w0, 0);
        check("rstf_x_out", x_out, 0);
        check("rstf_area2", area2_out, 0);
        tick();
        rmode = 0;
        load_tri(0, 0, 10, 0, 0, 10, 1'b0);
        send_px(2, 3);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
